// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file for the pipelined CPU datapath with a per-register busy
//   scoreboard. NUM_RD combinational read ports, one clocked write port,
//   one hardwired-zero register, optional same-cycle write-to-read bypass.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset (clears data and scoreboard)
//   wr_en        writeback valid
//   wr_addr      writeback register index
//   wr_data      writeback data
//   iss_en       instruction issued with a destination
//   iss_addr     destination register being issued (marked busy)
//   rd_en        per-port read-in-use flags
//   rd_addr      packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   rd_data      packed read data,      port i = [i*DATA_W +: DATA_W]
//   rd_busy      per-port "register has a pending write" flags
//   stall        any in-use port reads a busy register
//   pending_cnt  number of busy registers (registered counter)
module regfile_scoreboard #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  output logic [ADDR_W:0]          pending_cnt
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_pending;

  logic              w_wr_ok;
  logic              w_iss_ok;
  logic              w_inc;
  logic              w_dec;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W-1:0] w_raddr [NUM_RD];

  // The zero register is excluded from both writes and the scoreboard.
  assign w_wr_ok  = wr_en  && (wr_addr  != ZERO_ADDR);
  assign w_iss_ok = iss_en && (iss_addr != ZERO_ADDR);

  // Counter tracks busy-bit transitions only: issuing to a busy register
  // adds nothing, and a writeback cancelled by a same-address issue
  // (set wins) removes nothing.
  assign w_inc = w_iss_ok && !r_busy[iss_addr];
  assign w_dec = w_wr_ok && r_busy[wr_addr] &&
                 !(w_iss_ok && (iss_addr == wr_addr));

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)  w_busy_nxt[wr_addr]  = 1'b0;
    if (w_iss_ok) w_busy_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_pending <= r_pending + {{ADDR_W{1'b0}}, w_inc}
                             - {{ADDR_W{1'b0}}, w_dec};
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      w_raddr[i] = rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Read priority: zero register, then same-cycle bypass (which also hides
  // the busy bit about to be cleared), then stored state.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (w_raddr[i] == ZERO_ADDR) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_busy[i]                  = 1'b0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == w_raddr[i])) begin
        rd_data[i*DATA_W +: DATA_W] = wr_data;
        rd_busy[i]                  = 1'b0;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = r_regs[w_raddr[i]];
        rd_busy[i]                  = r_busy[w_raddr[i]];
      end
    end
  end

  assign stall       = |(rd_en & rd_busy);
  assign pending_cnt = r_pending;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Self-checking bench for regfile_scoreboard (default parameters).
//   A behavioural model (plain arrays + popcount) is compared against the
//   DUT on every falling clock edge; directed sequences add literal checks.
module tb_regfile_scoreboard;

  localparam int DW  = 64;
  localparam int AW  = 5;
  localparam int NR  = 2;
  localparam int ZR  = 31;
  localparam int BYP = 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             stall;
  logic [AW:0]      pending_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [DW-1:0] mmem [32];
  logic [31:0]   mbusy;

  // Compare-process scratch
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;
  logic          c_busy;
  logic          c_stall;

  regfile_scoreboard #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(ZR), .BYPASS(BYP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall),
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: reset clears everything at once
  always @(negedge reset_n) begin
    for (int k = 0; k < 32; k++) mmem[k] <= '0;
    mbusy <= '0;
  end

  // Model: clocked update from the rules (clear, then set wins)
  always @(posedge clk) begin
    if (reset_n) begin
      if (wr_en && wr_addr != 5'(ZR)) begin
        mmem[wr_addr]  <= wr_data;
        mbusy[wr_addr] <= 1'b0;
      end
      if (iss_en && iss_addr != 5'(ZR)) mbusy[iss_addr] <= 1'b1;
    end
  end

  // Compare process: combinational outputs vs model, every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      c_stall = 1'b0;
      for (int i = 0; i < NR; i++) begin
        c_addr = rd_addr[i*AW +: AW];
        if (c_addr == 5'(ZR)) begin
          c_data = '0; c_busy = 1'b0;
        end else if (BYP != 0 && wr_en && wr_addr == c_addr) begin
          c_data = wr_data; c_busy = 1'b0;
        end else begin
          c_data = mmem[c_addr]; c_busy = mbusy[c_addr];
        end
        chk($sformatf("model_rd_data%0d", i), rd_data[i*DW +: DW], c_data);
        chk($sformatf("model_rd_busy%0d", i), 64'(rd_busy[i]), 64'(c_busy));
        c_stall = c_stall | (rd_en[i] & c_busy);
      end
      chk("model_stall", 64'(stall), 64'(c_stall));
      chk("model_pending", 64'(pending_cnt), 64'($countones(mbusy)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] en);
    rd_addr = {a1, a0};
    rd_en   = en;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    iss_en = 1'b0;
  endtask

  function automatic logic [4:0] raddr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 9) return 5'd31;
    if (r == 8) return 5'($urandom_range(0, 31));
    return 5'(r);
  endfunction

  initial begin
    reset_n = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    rd_en = '0; rd_addr = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;

    // Reset state: every register reads zero and idle
    for (int a = 0; a < 32; a += 2) begin
      set_rd(5'(a), 5'(a + 1), 2'b11);
      @(negedge clk);
      chk("reset_rd0", rd_data[63:0], 64'h0);
      chk("reset_rd1", rd_data[127:64], 64'h0);
      chk("reset_busy", 64'(rd_busy), 64'h0);
      chk("reset_pending", 64'(pending_cnt), 64'h0);
      tick();
    end

    // Write then read next cycle
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0123_4567;
    set_rd(5'd0, 5'd1, 2'b00);
    tick();
    idle(); set_rd(5'd5, 5'd5, 2'b11);
    @(negedge clk);
    chk("wr5_rd0", rd_data[63:0], 64'hDEAD_BEEF_0123_4567);
    chk("wr5_rd1", rd_data[127:64], 64'hDEAD_BEEF_0123_4567);
    tick();

    // Writes to the zero register are discarded
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
    tick();
    idle(); set_rd(5'd31, 5'd31, 2'b11);
    @(negedge clk);
    chk("zero_rd0", rd_data[63:0], 64'h0);
    chk("zero_rd1", rd_data[127:64], 64'h0);
    tick();

    // Same-cycle bypass
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h55;
    set_rd(5'd7, 5'd0, 2'b01);
    @(negedge clk);
    chk("bypass_rd0", rd_data[63:0], 64'h55);
    tick();
    idle();
    @(negedge clk);
    chk("after_bypass_rd0", rd_data[63:0], 64'h55);
    tick();

    // Scoreboard: issue, stall, writeback clears
    iss_en = 1'b1; iss_addr = 5'd3; set_rd(5'd0, 5'd0, 2'b00);
    tick();
    idle(); set_rd(5'd3, 5'd0, 2'b01);
    @(negedge clk);
    chk("sb_busy0", 64'(rd_busy[0]), 64'h1);
    chk("sb_stall", 64'(stall), 64'h1);
    chk("sb_pending1", 64'(pending_cnt), 64'h1);
    tick();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1234;
    @(negedge clk);
    chk("sb_wb_stall", 64'(stall), 64'h0);
    chk("sb_wb_rd0", rd_data[63:0], 64'h1234);
    tick();
    idle();
    @(negedge clk);
    chk("sb_pending0", 64'(pending_cnt), 64'h0);
    tick();

    // Simultaneous issue and writeback
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'd99;
    tick();
    idle(); set_rd(5'd9, 5'd4, 2'b11);
    @(negedge clk);
    chk("sim_same_pending", 64'(pending_cnt), 64'h1);
    chk("sim_same_busy", 64'(rd_busy), 64'h1);
    chk("sim_same_data", rd_data[63:0], 64'd99);
    tick();
    iss_en = 1'b1; iss_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'd100;
    tick();
    idle(); set_rd(5'd9, 5'd4, 2'b11);
    @(negedge clk);
    chk("sim_move_pending", 64'(pending_cnt), 64'h1);
    chk("sim_move_busy", 64'(rd_busy), 64'h2);
    tick();

    // Randomized traffic with occasional asynchronous reset pulses
    for (int n = 0; n < 3000; n++) begin
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = raddr();
      wr_data  = {$urandom, $urandom};
      iss_en   = ($urandom_range(0, 2) != 0);
      iss_addr = raddr();
      set_rd(raddr(), raddr(), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 99) == 0) begin
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      tick();
    end

    // Asynchronous reset mid-stream with five busy registers
    idle();
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    for (int r = 10; r < 15; r++) begin
      iss_en = 1'b1; iss_addr = 5'(r);
      wr_en = 1'b1; wr_addr = 5'(r); wr_data = 64'(r * 3 + 1);
      tick();
    end
    idle(); set_rd(5'd10, 5'd14, 2'b11);
    @(negedge clk);
    chk("ar_pre_pending", 64'(pending_cnt), 64'h5);
    chk("ar_pre_stall", 64'(stall), 64'h1);
    chk("ar_pre_rd0", rd_data[63:0], 64'd31);
    chk("ar_pre_rd1", rd_data[127:64], 64'd43);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_pending", 64'(pending_cnt), 64'h0);
    chk("ar_stall", 64'(stall), 64'h0);
    chk("ar_busy", 64'(rd_busy), 64'h0);
    chk("ar_rd0", rd_data[63:0], 64'h0);
    chk("ar_rd1", rd_data[127:64], 64'h0);
    #1 reset_n = 1'b1;
    tick();
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'd77;
    tick();
    idle();
    @(negedge clk);
    chk("ar_after_rd0", rd_data[63:0], 64'd77);
    chk("ar_after_pending", 64'(pending_cnt), 64'h0);
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
